// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with 2-bit saturating direction counters,
// round-robin replacement per set, and a saturating mispredict statistic.
module btb_assoc #(
    parameter int ADDR_W   = 32,
    parameter int NUM_SETS = 8,
    parameter int NUM_WAYS = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] PC,
    input  logic              update,
    input  logic [ADDR_W-1:0] updatePC,
    input  logic [ADDR_W-1:0] updateTarget,
    input  logic              updateTaken,
    input  logic              mispredicted,
    input  logic              flush,
    output logic              valid,
    output logic [ADDR_W-1:0] target,
    output logic              predictedTaken,
    output logic [CNT_W-1:0]  mispredict_count
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;
    // A single-way BTB still gets a 1-bit pointer so the arrays stay legal; it never moves.
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    logic [NUM_SETS-1:0][NUM_WAYS-1:0]             val_q,  val_d;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0][TAG_W-1:0]  tag_q,  tag_d;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0][ADDR_W-1:0] tgt_q,  tgt_d;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0][1:0]        ctr_q,  ctr_d;
    logic [NUM_SETS-1:0][WAY_W-1:0]                vptr_q, vptr_d;
    logic [CNT_W-1:0]                              mcnt_q, mcnt_d;

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic             u_hit, inv_found;
    logic [WAY_W-1:0] u_way, inv_way, alloc_way, vptr_nxt;
    logic [3:0]       pc_lo_unused;

    assign l_idx = PC[2 +: IDX_W];
    assign l_tag = PC[ADDR_W-1 -: TAG_W];
    assign u_idx = updatePC[2 +: IDX_W];
    assign u_tag = updatePC[ADDR_W-1 -: TAG_W];
    assign pc_lo_unused = {PC[1:0], updatePC[1:0]};

    // Lookup: descending scan so the lowest matching way wins.
    always_comb begin
        valid          = 1'b0;
        target         = '0;
        predictedTaken = 1'b0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (val_q[l_idx][w] && tag_q[l_idx][w] == l_tag) begin
                valid          = 1'b1;
                target         = tgt_q[l_idx][w];
                predictedTaken = ctr_q[l_idx][w][1];
            end
        end
    end

    always_comb begin
        u_hit     = 1'b0;
        u_way     = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (val_q[u_idx][w] && tag_q[u_idx][w] == u_tag) begin
                u_hit = 1'b1;
                u_way = WAY_W'(w);
            end
            if (!val_q[u_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign alloc_way = inv_found ? inv_way : vptr_q[u_idx];
    assign vptr_nxt  = (NUM_WAYS == 1 || vptr_q[u_idx] == WAY_W'(NUM_WAYS - 1))
                       ? '0 : vptr_q[u_idx] + 1'b1;

    always_comb begin
        val_d  = val_q;
        tag_d  = tag_q;
        tgt_d  = tgt_q;
        ctr_d  = ctr_q;
        vptr_d = vptr_q;
        if (flush) begin
            val_d  = '0;
            vptr_d = '0;
        end else if (update) begin
            if (u_hit) begin
                if (updateTaken) begin
                    tgt_d[u_idx][u_way] = updateTarget;
                    if (ctr_q[u_idx][u_way] != 2'd3)
                        ctr_d[u_idx][u_way] = ctr_q[u_idx][u_way] + 2'd1;
                end else if (ctr_q[u_idx][u_way] != 2'd0) begin
                    ctr_d[u_idx][u_way] = ctr_q[u_idx][u_way] - 2'd1;
                end
            end else if (updateTaken) begin
                val_d[u_idx][alloc_way] = 1'b1;
                tag_d[u_idx][alloc_way] = u_tag;
                tgt_d[u_idx][alloc_way] = updateTarget;
                ctr_d[u_idx][alloc_way] = 2'd2;
                // Pointer only moves when a live entry is displaced.
                if (!inv_found)
                    vptr_d[u_idx] = vptr_nxt;
            end
        end
    end

    always_comb begin
        mcnt_d = mcnt_q;
        if (update && mispredicted && mcnt_q != {CNT_W{1'b1}})
            mcnt_d = mcnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q  <= '0;
            tag_q  <= '0;
            tgt_q  <= '0;
            ctr_q  <= '0;
            vptr_q <= '0;
            mcnt_q <= '0;
        end else begin
            val_q  <= val_d;
            tag_q  <= tag_d;
            tgt_q  <= tgt_d;
            ctr_q  <= ctr_d;
            vptr_q <= vptr_d;
            mcnt_q <= mcnt_d;
        end
    end

    assign mispredict_count = mcnt_q;

endmodule
